// File: rtl/dm_arb_pkg.sv
// Shared constants and types for the data-memory arbiter (CPU vs host port).
package dm_arb_pkg;

  localparam int unsigned ADDR_W               = 32'd4;
  localparam int unsigned DATA_W               = 32'd4;
  localparam int unsigned DEFAULT_STARVE_LIMIT = 32'd8;

  // IDLE: host not waiting, WAIT: host refused for a while, FORCE: stall cycle.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_WAIT  = 2'd1,
    ARB_FORCE = 2'd2
  } arb_state_e;

  // Width of a counter that can hold 0..limit, never narrower than one bit.
  function automatic int unsigned wait_cnt_width(input int unsigned limit);
    int unsigned w;
    w = $clog2(limit + 32'd1);
    return (w == 32'd0) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/dm_arbiter.sv
// Arbiter for the single-port data memory: CPU has priority, the host gets idle
// cycles, and a starvation counter forces one CPU stall cycle so the host
// always makes progress. The memory itself is clocked on ~clk.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
  parameter int unsigned CW           = wait_cnt_width(STARVE_LIMIT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_en,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic [CW-1:0]     wait_cnt
);

  localparam logic [CW-1:0] LIMIT_C  = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0] ONE_C    = CW'(32'd1);
  localparam bit            FORCE_EN = (STARVE_LIMIT != 32'd0);

  arb_state_e        state_q, state_d;
  logic [CW-1:0]     wait_cnt_q, wait_cnt_d;
  logic [CW-1:0]     cnt_inc_s;
  logic              host_rvalid_q, host_rvalid_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic              force_s;
  logic              force_set_s;
  logic              host_gnt_s;

  // State register plus wait counter and registered host read return.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ARB_IDLE;
      wait_cnt_q    <= '0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
    end
  end

  // Next state: count refused host cycles and schedule the forced stall.
  always_comb begin
    state_d       = ARB_IDLE;
    wait_cnt_d    = wait_cnt_q;
    host_rvalid_d = 1'b0;
    host_rdata_d  = host_rdata_q;
    cnt_inc_s     = wait_cnt_q + ONE_C;

    if (host_gnt_s || !host_req) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q == LIMIT_C) begin
      wait_cnt_d = wait_cnt_q;
    end else begin
      wait_cnt_d = cnt_inc_s;
    end

    // The stall lands in the cycle after the LIMIT-th consecutive refusal;
    // the grant it produces clears the counter, so FORCE lasts one cycle.
    force_set_s = FORCE_EN && host_req && !host_gnt_s && (cnt_inc_s == LIMIT_C);

    if (force_set_s) begin
      state_d = ARB_FORCE;
    end else if (wait_cnt_d != '0) begin
      state_d = ARB_WAIT;
    end else begin
      state_d = ARB_IDLE;
    end

    // Host read data is captured at the edge ending its grant cycle.
    if (host_gnt_s && !host_we) begin
      host_rvalid_d = 1'b1;
      host_rdata_d  = mem_q;
    end else begin
      host_rvalid_d = 1'b0;
      host_rdata_d  = host_rdata_q;
    end
  end

  // Outputs: grant decision and memory port steering.
  always_comb begin
    force_s = 1'b0;
    case (state_q)
      ARB_FORCE:          force_s = 1'b1;
      ARB_IDLE, ARB_WAIT: force_s = 1'b0;
      default:            force_s = 1'b0;
    endcase

    host_gnt_s = host_req & (~cpu_en | force_s);

    if (host_gnt_s) begin
      mem_addr = host_addr;
      mem_data = host_wdata;
      mem_wren = host_we;
    end else begin
      // A stalled CPU must never write, even when the host left the slot empty.
      mem_addr = cpu_addr;
      mem_data = cpu_wdata;
      mem_wren = cpu_en & cpu_we & ~force_s;
    end
  end

  assign cpu_rdata   = mem_q;
  assign cpu_stall   = force_s;
  assign host_gnt    = host_gnt_s;
  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;
  assign wait_cnt    = wait_cnt_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: combinational table, directed corner
// sequences, a STARVE_LIMIT=0 instance, and randomized traffic vs a model.
module tb_dm_arbiter;
  import dm_arb_pkg::*;

  localparam int LIMIT = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       cpu_en, cpu_we, host_req, host_we;
  logic [3:0] cpu_addr, cpu_wdata, host_addr, host_wdata;
  logic [3:0] cpu_rdata, host_rdata, mem_addr, mem_data, mem_q;
  logic       cpu_stall, host_gnt, host_rvalid, mem_wren;
  logic [3:0] wait_cnt;

  logic [3:0] b_cpu_rdata, b_host_rdata, b_mem_addr, b_mem_data;
  logic       b_cpu_stall, b_host_gnt, b_host_rvalid, b_mem_wren;
  logic [0:0] b_wait_cnt;
  logic [3:0] b_mem_q = 4'h0;

  int total = 0;
  int bad   = 0;

  dm_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q),
    .wait_cnt(wait_cnt)
  );

  dm_arbiter #(.STARVE_LIMIT(0)) dut0 (
    .clk(clk), .reset(reset),
    .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(b_cpu_rdata), .cpu_stall(b_cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(b_host_gnt), .host_rvalid(b_host_rvalid), .host_rdata(b_host_rdata),
    .mem_addr(b_mem_addr), .mem_data(b_mem_data), .mem_wren(b_mem_wren), .mem_q(b_mem_q),
    .wait_cnt(b_wait_cnt)
  );

  // Data memory model on the falling edge (old data on read-during-write).
  function automatic logic [3:0] mem_init(input int i);
    case (i)
      0:       return 4'h4;
      1:       return 4'hB;
      3:       return 4'hA;
      default: return 4'(i * 3 + 1);
    endcase
  endfunction

  logic [3:0] mem [16];
  logic       mem_ready = 1'b0;
  always @(negedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 16; i++) mem[i] <= mem_init(i);
      mem_ready <= 1'b1;
    end else begin
      mem_q <= mem[mem_addr];
      if (mem_wren) mem[mem_addr] <= mem_data;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_en = 1'b0; cpu_we = 1'b0; cpu_addr = 4'h0; cpu_wdata = 4'h0;
    host_req = 1'b0; host_we = 1'b0; host_addr = 4'h0; host_wdata = 4'h0;
  endtask

  typedef struct {
    logic       cpu_en, cpu_we;
    logic [3:0] cpu_addr, cpu_wdata;
    logic       host_req, host_we;
    logic [3:0] host_addr, host_wdata;
    logic       exp_gnt;
    logic [3:0] exp_addr, exp_data;
    logic       exp_wren;
  } vec_t;
  vec_t vt [6];

  // Random-phase model state
  int         denied;
  bit         stall_m, rv_m, rv_next, stall_next, exp_gnt, exp_wren, cpu_rd_chk;
  logic [3:0] rd_m, rd_next, exp_cpu_q;
  logic [3:0] shadow [16];

  initial begin
    vt[0] = '{1'b1, 1'b1, 4'h2, 4'h5, 1'b1, 1'b1, 4'h7, 4'hF, 1'b0, 4'h2, 4'h5, 1'b1};
    vt[1] = '{1'b0, 1'b1, 4'h2, 4'h5, 1'b1, 1'b0, 4'h7, 4'hF, 1'b1, 4'h7, 4'hF, 1'b0};
    vt[2] = '{1'b0, 1'b1, 4'h3, 4'h6, 1'b0, 1'b1, 4'h8, 4'h1, 1'b0, 4'h3, 4'h6, 1'b0};
    vt[3] = '{1'b1, 1'b0, 4'h4, 4'h1, 1'b0, 1'b0, 4'h5, 4'h2, 1'b0, 4'h4, 4'h1, 1'b0};
    vt[4] = '{1'b0, 1'b0, 4'h8, 4'h2, 1'b1, 1'b1, 4'hC, 4'h9, 1'b1, 4'hC, 4'h9, 1'b1};
    vt[5] = '{1'b1, 1'b1, 4'hE, 4'h3, 1'b0, 1'b1, 4'h6, 4'h4, 1'b0, 4'hE, 4'h3, 1'b1};

    reset = 1'b0;
    idle_inputs();
    @(negedge clk); @(negedge clk);
    advance();

    // Reset state
    chk("rst_wait_cnt", 32'(wait_cnt), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_rvalid", 32'(host_rvalid), 32'd0);
    chk("rst_rdata", 32'(host_rdata), 32'd0);

    // Combinational grant/mux table (held in reset: no stall, counter 0)
    for (int i = 0; i < 6; i++) begin
      cpu_en = vt[i].cpu_en; cpu_we = vt[i].cpu_we;
      cpu_addr = vt[i].cpu_addr; cpu_wdata = vt[i].cpu_wdata;
      host_req = vt[i].host_req; host_we = vt[i].host_we;
      host_addr = vt[i].host_addr; host_wdata = vt[i].host_wdata;
      #1;
      chk($sformatf("tbl%0d_gnt", i), 32'(host_gnt), 32'(vt[i].exp_gnt));
      chk($sformatf("tbl%0d_addr", i), 32'(mem_addr), 32'(vt[i].exp_addr));
      chk($sformatf("tbl%0d_data", i), 32'(mem_data), 32'(vt[i].exp_data));
      chk($sformatf("tbl%0d_wren", i), 32'(mem_wren), 32'(vt[i].exp_wren));
    end
    idle_inputs();
    @(negedge clk); reset = 1'b1;
    advance();

    // Reset mid-wait, then counter rebuilds up to a forced grant
    cpu_en = 1'b1; host_req = 1'b1; host_we = 1'b0; host_addr = 4'h3;
    for (int i = 0; i < 5; i++) begin
      #1 chk("midwait_gnt", 32'(host_gnt), 32'd0);
      advance();
    end
    chk("midwait_cnt5", 32'(wait_cnt), 32'd5);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_cnt", 32'(wait_cnt), 32'd0);
    chk("async_rst_gnt", 32'(host_gnt), 32'd0);
    chk("async_rst_stall", 32'(cpu_stall), 32'd0);
    @(negedge clk); reset = 1'b1;
    #1;
    for (int i = 0; i < LIMIT; i++) begin
      chk($sformatf("rebuild_cnt%0d", i), 32'(wait_cnt), 32'(i));
      chk("rebuild_gnt", 32'(host_gnt), 32'd0);
      advance();
    end
    chk("rebuild_force_stall", 32'(cpu_stall), 32'd1);
    chk("rebuild_force_gnt", 32'(host_gnt), 32'd1);
    advance();
    host_req = 1'b0;
    #1;
    chk("rebuild_rvalid", 32'(host_rvalid), 32'd1);
    chk("rebuild_rdata", 32'(host_rdata), 32'hA);
    chk("rebuild_unstall", 32'(cpu_stall), 32'd0);
    advance();

    // Idle CPU: host read of addr 3
    idle_inputs();
    host_req = 1'b1; host_addr = 4'h3;
    #1;
    chk("idle_gnt", 32'(host_gnt), 32'd1);
    chk("idle_addr", 32'(mem_addr), 32'h3);
    advance();
    host_req = 1'b0;
    #1;
    chk("idle_rvalid", 32'(host_rvalid), 32'd1);
    chk("idle_rdata", 32'(host_rdata), 32'hA);
    advance();
    chk("idle_rvalid_drop", 32'(host_rvalid), 32'd0);

    // CPU priority on the same address, host write follows
    cpu_en = 1'b1; cpu_we = 1'b1; cpu_addr = 4'h2; cpu_wdata = 4'h5;
    host_req = 1'b1; host_we = 1'b1; host_addr = 4'h2; host_wdata = 4'hF;
    #1;
    chk("prio_gnt", 32'(host_gnt), 32'd0);
    chk("prio_cpu_data", 32'(mem_data), 32'h5);
    chk("prio_cpu_wren", 32'(mem_wren), 32'd1);
    advance();
    chk("prio_mem_cpu", 32'(mem[2]), 32'h5);
    cpu_en = 1'b0;
    #1;
    chk("prio_host_gnt", 32'(host_gnt), 32'd1);
    chk("prio_host_data", 32'(mem_data), 32'hF);
    advance();
    host_req = 1'b0;
    #1;
    chk("prio_mem_final", 32'(mem[2]), 32'hF);
    chk("prio_host_wr_norvalid", 32'(host_rvalid), 32'd0);
    advance();

    // Starvation: host write 7 to addr 9 against a busy CPU
    cpu_en = 1'b1; cpu_we = 1'b1; cpu_addr = 4'h5; cpu_wdata = 4'hC;
    host_req = 1'b1; host_we = 1'b1; host_addr = 4'h9; host_wdata = 4'h7;
    for (int i = 0; i < LIMIT; i++) begin
      #1;
      chk("starve_gnt", 32'(host_gnt), 32'd0);
      chk("starve_stall", 32'(cpu_stall), 32'd0);
      chk($sformatf("starve_cnt%0d", i), 32'(wait_cnt), 32'(i));
      advance();
    end
    chk("starve9_stall", 32'(cpu_stall), 32'd1);
    chk("starve9_gnt", 32'(host_gnt), 32'd1);
    chk("starve9_cnt", 32'(wait_cnt), 32'(LIMIT));
    chk("starve9_addr", 32'(mem_addr), 32'h9);
    chk("starve9_wren", 32'(mem_wren), 32'd1);
    advance();
    host_req = 1'b0;
    #1;
    chk("starve10_stall", 32'(cpu_stall), 32'd0);
    chk("starve10_cnt", 32'(wait_cnt), 32'd0);
    chk("starve_mem9", 32'(mem[9]), 32'h7);
    advance();

    // Host drops req in the force cycle: bubble, no CPU write
    cpu_addr = 4'h4; cpu_wdata = 4'h6;
    host_req = 1'b1; host_we = 1'b1; host_addr = 4'hD; host_wdata = 4'h1;
    for (int i = 0; i < LIMIT; i++) begin
      #1 chk("bubble_wait_gnt", 32'(host_gnt), 32'd0);
      advance();
    end
    host_req = 1'b0; cpu_wdata = 4'hE;
    #1;
    chk("bubble_stall", 32'(cpu_stall), 32'd1);
    chk("bubble_gnt", 32'(host_gnt), 32'd0);
    chk("bubble_wren", 32'(mem_wren), 32'd0);
    advance();
    chk("bubble_mem4", 32'(mem[4]), 32'h6);
    chk("bubble_cnt", 32'(wait_cnt), 32'd0);
    chk("bubble_unstall", 32'(cpu_stall), 32'd0);

    // cpu_en=0 in the force cycle: grant, stall still asserted
    cpu_we = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 4'h9;
    for (int i = 0; i < LIMIT; i++) advance();
    cpu_en = 1'b0;
    #1;
    chk("idleforce_gnt", 32'(host_gnt), 32'd1);
    chk("idleforce_stall", 32'(cpu_stall), 32'd1);
    advance();
    host_req = 1'b0;
    #1;
    chk("idleforce_rdata", 32'(host_rdata), 32'h7);
    chk("idleforce_unstall", 32'(cpu_stall), 32'd0);
    advance();

    // Back-to-back host reads of 0,1,2
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      host_req = (k < 3);
      host_addr = 4'(k);
      #1;
      if (k < 3) chk($sformatf("b2b_gnt%0d", k), 32'(host_gnt), 32'd1);
      if (k > 0) begin
        chk($sformatf("b2b_rvalid%0d", k - 1), 32'(host_rvalid), 32'd1);
        chk($sformatf("b2b_rdata%0d", k - 1), 32'(host_rdata),
            (k == 1) ? 32'h4 : (k == 2) ? 32'hB : 32'hF);
      end
      advance();
    end
    chk("b2b_rvalid_end", 32'(host_rvalid), 32'd0);

    // STARVE_LIMIT=0 instance: never grants against a busy CPU, never stalls
    cpu_en = 1'b1; cpu_we = 1'b0; host_req = 1'b1; host_we = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #1;
      chk("nolimit_gnt", 32'(b_host_gnt), 32'd0);
      chk("nolimit_stall", 32'(b_cpu_stall), 32'd0);
      advance();
    end
    chk("nolimit_cnt", 32'(b_wait_cnt), 32'd0);

    // Randomized traffic against a behavioural model
    idle_inputs();
    reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    advance();
    for (int i = 0; i < 16; i++) shadow[i] = mem[i];
    denied = 0; stall_m = 1'b0; rv_m = 1'b0; rd_m = 4'h0;
    for (int c = 0; c < 800; c++) begin
      if (!host_req) begin
        if ($urandom_range(0, 2) == 0) begin
          host_req = 1'b1;
          host_we = 1'($urandom_range(0, 1));
          host_addr = 4'($urandom_range(0, 15));
          host_wdata = 4'($urandom_range(0, 15));
        end
      end else if ($urandom_range(0, 40) == 0) begin
        host_req = 1'b0;
      end
      cpu_en = ($urandom_range(0, 9) < 8);
      cpu_we = 1'($urandom_range(0, 1));
      cpu_addr = 4'($urandom_range(0, 15));
      cpu_wdata = 4'($urandom_range(0, 15));
      #1;
      // Host wins when the CPU is idle or the CPU is being held in a stall.
      exp_gnt = host_req && (!cpu_en || stall_m);
      exp_wren = exp_gnt ? host_we : (cpu_en && cpu_we && !stall_m);
      chk("rnd_gnt", 32'(host_gnt), 32'(exp_gnt));
      chk("rnd_stall", 32'(cpu_stall), 32'(stall_m));
      chk("rnd_wait", 32'(wait_cnt), 32'(denied));
      chk("rnd_rvalid", 32'(host_rvalid), 32'(rv_m));
      chk("rnd_rdata", 32'(host_rdata), 32'(rd_m));
      chk("rnd_wren", 32'(mem_wren), 32'(exp_wren));
      if (exp_wren) begin
        chk("rnd_waddr", 32'(mem_addr), exp_gnt ? 32'(host_addr) : 32'(cpu_addr));
        chk("rnd_wdata", 32'(mem_data), exp_gnt ? 32'(host_wdata) : 32'(cpu_wdata));
      end
      cpu_rd_chk = cpu_en && !exp_gnt;
      exp_cpu_q = shadow[cpu_addr];
      rv_next = exp_gnt && !host_we;
      rd_next = shadow[host_addr];
      if (exp_wren) begin
        if (exp_gnt) shadow[host_addr] = host_wdata;
        else shadow[cpu_addr] = cpu_wdata;
      end
      @(negedge clk);
      #1;
      if (cpu_rd_chk) chk("rnd_cpu_rdata", 32'(cpu_rdata), 32'(exp_cpu_q));
      @(posedge clk);
      #1;
      if (rv_next) rd_m = rd_next;
      rv_m = rv_next;
      // After LIMIT refusals in a row the next cycle is a forced stall.
      stall_next = host_req && !exp_gnt && (denied + 1 == LIMIT);
      if (host_req && !exp_gnt) denied = (denied + 1 > LIMIT) ? LIMIT : denied + 1;
      else denied = 0;
      stall_m = stall_next;
      if (exp_gnt) host_req = 1'b0;
    end
    idle_inputs();
    advance();
    for (int i = 0; i < 16; i++) chk($sformatf("rnd_mem%0d", i), 32'(mem[i]), 32'(shadow[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
